// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port data RAM between instruction fetch (port 0, read
// only) and the memory stage (port 1, load/store). One access is in flight at
// a time: the winning request is latched onto the RAM bus, the design waits
// RAM_LATENCY cycles, captures ram_rdata into the granted port's read-data
// register and then pulses that port's acknowledge for exactly one cycle.
//
// Parameters:
//   ADDR_W       address width of both ports and the RAM
//   DATA_W       data width of both ports and the RAM
//   RAM_LATENCY  cycles from address presentation to valid ram_rdata (1..15)
//
// Ports:
//   clk, rst                 clock (posedge) and asynchronous active-low reset
//   p0_req/p0_addr           fetch request, held until p0_ack
//   p0_ack/p0_rdata          one-cycle completion pulse and read data
//   p1_req/p1_we/p1_addr/    memory-stage request, held until p1_ack
//   p1_wdata
//   p1_ack/p1_rdata          one-cycle completion pulse and load data
//   ram_addr/ram_wdata/      registered RAM request; ram_we only in the first
//   ram_we                   access cycle
//   ram_rdata                RAM read data
//   busy                     high whenever an access is in progress
//   grant_id                 port owning the RAM (meaningful while busy)
//
// Optional feature:
//   MEM_ARB_ROUND_ROBIN_EN   when defined, simultaneous requests are resolved
//                            round-robin; otherwise port 1 always wins.
// ----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int RAM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic [ADDR_W-1:0] p0_addr,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
    output logic              grant_id
);

    generate
        if (RAM_LATENCY < 1 || RAM_LATENCY > 15) begin : gLatencyCheck
            $error("mem_port_arbiter: RAM_LATENCY must be in 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    localparam logic [3:0] LAT_LOAD = 4'(RAM_LATENCY);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              ram_we_q, ram_we_d;
    logic              grant_q, grant_d;
    logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
    logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;
    logic              pick1;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic              rr_q, rr_d;

    // Under contention the pointer picks the winner; a lone requester wins.
    always_comb begin
        if (p0_req && p1_req) begin
            pick1 = rr_q;
        end else begin
            pick1 = p1_req;
        end
    end
`else
    // Port 1 has fixed priority; port 0 only wins when port 1 is idle.
    always_comb begin
        pick1 = p1_req;
    end
`endif

    // Next-state logic. ram_we defaults low so it is only asserted for the
    // single cycle following the grant edge.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_we_d    = 1'b0;
        grant_d     = grant_q;
        p0_rdata_d  = p0_rdata_q;
        p1_rdata_d  = p1_rdata_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        rr_d        = rr_q;
`endif

        case (state_q)
            IDLE: begin
                if (p0_req || p1_req) begin
                    state_d = ACCESS;
                    cnt_d   = LAT_LOAD;
                    grant_d = pick1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    rr_d    = ~pick1;
`endif
                    if (pick1) begin
                        ram_addr_d  = p1_addr;
                        ram_wdata_d = p1_wdata;
                        ram_we_d    = p1_we;
                    end else begin
                        // Fetch is read-only; the write-data bus keeps its value.
                        ram_addr_d  = p0_addr;
                    end
                end
            end

            ACCESS: begin
                cnt_d = cnt_q - 4'd1;
                // Last latency cycle: read data is valid now, capture it even
                // for stores so the port register always reflects the access.
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    if (grant_q) begin
                        p1_rdata_d = ram_rdata;
                    end else begin
                        p0_rdata_d = ram_rdata;
                    end
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any access immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_we_q    <= 1'b0;
            grant_q     <= 1'b0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            rr_q        <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_we_q    <= ram_we_d;
            grant_q     <= grant_d;
            p0_rdata_q  <= p0_rdata_d;
            p1_rdata_q  <= p1_rdata_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            rr_q        <= rr_d;
`endif
        end
    end

    assign p0_ack    = (state_q == RESP) && !grant_q;
    assign p1_ack    = (state_q == RESP) &&  grant_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_we    = ram_we_q;
    assign busy      = (state_q != IDLE);
    assign grant_id  = grant_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Testbench for mem_port_arbiter. Instance dutA (RAM_LATENCY=1) runs directed
// scenarios and then random traffic, with every cycle compared against a
// transaction-level reference model. Instance dutB (RAM_LATENCY=3) runs one
// directed read to pin down the longer-latency timing.
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int LAT  = 1;
    localparam int LATB = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;

    logic          p0Req = 1'b0;
    logic [AW-1:0] p0Addr = '0;
    logic          p0Ack;
    logic [DW-1:0] p0Rdata;
    logic          p1Req = 1'b0;
    logic          p1We = 1'b0;
    logic [AW-1:0] p1Addr = '0;
    logic [DW-1:0] p1Wdata = '0;
    logic          p1Ack;
    logic [DW-1:0] p1Rdata;
    logic [AW-1:0] ramAddr;
    logic [DW-1:0] ramWdata;
    logic          ramWe;
    logic [DW-1:0] ramRdata = '0;
    logic          busy;
    logic          grantId;

    logic          bP0Req = 1'b0;
    logic [AW-1:0] bP0Addr = '0;
    logic          bP0Ack;
    logic [DW-1:0] bP0Rdata;
    logic          bP1Ack;
    logic [DW-1:0] bP1Rdata;
    logic [AW-1:0] bRamAddr;
    logic [DW-1:0] bRamWdata;
    logic          bRamWe;
    logic [DW-1:0] bRamRdata = '0;
    logic          bBusy;
    logic          bGrantId;

    int checkCount = 0;
    int errorCount = 0;
    bit draining   = 1'b0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RAM_LATENCY(LAT)) dutA (
        .clk(clk), .rst(rst),
        .p0_req(p0Req), .p0_addr(p0Addr), .p0_ack(p0Ack), .p0_rdata(p0Rdata),
        .p1_req(p1Req), .p1_we(p1We), .p1_addr(p1Addr), .p1_wdata(p1Wdata),
        .p1_ack(p1Ack), .p1_rdata(p1Rdata),
        .ram_addr(ramAddr), .ram_wdata(ramWdata), .ram_we(ramWe),
        .ram_rdata(ramRdata), .busy(busy), .grant_id(grantId)
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RAM_LATENCY(LATB)) dutB (
        .clk(clk), .rst(rst),
        .p0_req(bP0Req), .p0_addr(bP0Addr), .p0_ack(bP0Ack), .p0_rdata(bP0Rdata),
        .p1_req(1'b0), .p1_we(1'b0), .p1_addr('0), .p1_wdata('0),
        .p1_ack(bP1Ack), .p1_rdata(bP1Rdata),
        .ram_addr(bRamAddr), .ram_wdata(bRamWdata), .ram_we(bRamWe),
        .ram_rdata(bRamRdata), .busy(bBusy), .grant_id(bGrantId)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference model: an access is described by the edge number at which it
    // was granted. Busy spans grantEdge..grantEdge+LAT, the ack follows edge
    // grantEdge+LAT, and a new grant is possible from grantEdge+LAT+2.
    int            edgeNo    = 0;
    int            grantEdge = -100;
    logic          mGrant    = 1'b0;
    logic          mWe       = 1'b0;
    logic [AW-1:0] mAddr     = '0;
    logic [DW-1:0] mWdata    = '0;
    logic [DW-1:0] mRd0      = '0;
    logic [DW-1:0] mRd1      = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic          mRr       = 1'b0;
`endif
    logic          win;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            edgeNo    = 0;
            grantEdge = -100;
            mGrant    = 1'b0;
            mWe       = 1'b0;
            mAddr     = '0;
            mWdata    = '0;
            mRd0      = '0;
            mRd1      = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            mRr       = 1'b0;
`endif
        end else begin
            edgeNo++;
            if (edgeNo == grantEdge + LAT) begin
                if (mGrant) mRd1 = ramRdata;
                else        mRd0 = ramRdata;
            end else if (edgeNo >= grantEdge + LAT + 2 && (p0Req || p1Req)) begin
                if (p0Req && p1Req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    win = mRr;
`else
                    win = 1'b1;
`endif
                end else begin
                    win = p1Req;
                end
`ifdef MEM_ARB_ROUND_ROBIN_EN
                mRr = !win;
`endif
                grantEdge = edgeNo;
                mGrant    = win;
                if (win) begin
                    mAddr  = p1Addr;
                    mWdata = p1Wdata;
                    mWe    = p1We;
                end else begin
                    mAddr  = p0Addr;
                    mWe    = 1'b0;
                end
            end
        end
    end

    logic eBusy, eAck0, eAck1, eWe;
    assign eBusy = (edgeNo >= grantEdge) && (edgeNo <= grantEdge + LAT);
    assign eAck0 = (edgeNo == grantEdge + LAT) && !mGrant;
    assign eAck1 = (edgeNo == grantEdge + LAT) &&  mGrant;
    assign eWe   = (edgeNo == grantEdge) && mWe;

    // Every cycle, compare all outputs of dutA against the model.
    always @(negedge clk) begin
        checkOutput("busy",     busy,     eBusy);
        checkOutput("p0_ack",   p0Ack,    eAck0);
        checkOutput("p1_ack",   p1Ack,    eAck1);
        checkOutput("ram_we",   ramWe,    eWe);
        checkOutput("ram_addr", ramAddr,  mAddr);
        checkOutput("ram_wdata", ramWdata, mWdata);
        checkOutput("p0_rdata", p0Rdata,  mRd0);
        checkOutput("p1_rdata", p1Rdata,  mRd1);
        if (eBusy) checkOutput("grant_id", grantId, mGrant);
    end

    task automatic applyStimulus();
        if (p0Req) begin
            if (eAck0) begin
                if (!draining && $urandom_range(1) == 1) p0Addr = $urandom;
                else                                     p0Req  = 1'b0;
            end
        end else if (!draining && $urandom_range(3) == 0) begin
            p0Req  = 1'b1;
            p0Addr = $urandom;
        end
        if (p1Req) begin
            if (eAck1) begin
                if (!draining && $urandom_range(1) == 1) begin
                    p1Addr  = $urandom;
                    p1Wdata = $urandom;
                    p1We    = 1'($urandom_range(1));
                end else begin
                    p1Req = 1'b0;
                end
            end
        end else if (!draining && $urandom_range(3) == 0) begin
            p1Req   = 1'b1;
            p1Addr  = $urandom;
            p1Wdata = $urandom;
            p1We    = 1'($urandom_range(1));
        end
        ramRdata = $urandom;
    endtask

    logic expFirst;
    logic [3:0] expOrder;
    int busyCycles;
    int ackCycle;
    int ackCount;
    logic [DW-1:0] gotRd;

    initial begin
        // Reset values.
        repeat (2) @(negedge clk);
        checkOutput("rst_busy",   busy,    1'b0);
        checkOutput("rst_ram_we", ramWe,   1'b0);
        checkOutput("rst_addr",   ramAddr, 32'h0);
        checkOutput("rst_p0_ack", p0Ack,   1'b0);
        rst = 1'b1;

        // Read on port 0 with latency 1.
        @(negedge clk);
        p0Req = 1'b1; p0Addr = 32'h40; ramRdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        checkOutput("t1_busy",     busy,    1'b1);
        checkOutput("t1_ram_addr", ramAddr, 32'h40);
        checkOutput("t1_ram_we",   ramWe,   1'b0);
        checkOutput("t1_ack_early", p0Ack,  1'b0);
        @(posedge clk); #1;
        checkOutput("t1_ack",   p0Ack,   1'b1);
        checkOutput("t1_rdata", p0Rdata, 32'hDEADBEEF);
        @(negedge clk); p0Req = 1'b0;
        @(posedge clk); #1;
        checkOutput("t1_ack_done", p0Ack, 1'b0);
        checkOutput("t1_idle",     busy,  1'b0);

        // Store on port 1.
        @(negedge clk);
        p1Req = 1'b1; p1We = 1'b1; p1Addr = 32'h100; p1Wdata = 32'h12345678;
        @(posedge clk); #1;
        checkOutput("t2_ram_we",    ramWe,    1'b1);
        checkOutput("t2_ram_addr",  ramAddr,  32'h100);
        checkOutput("t2_ram_wdata", ramWdata, 32'h12345678);
        checkOutput("t2_grant",     grantId,  1'b1);
        @(posedge clk); #1;
        checkOutput("t2_ram_we_off", ramWe, 1'b0);
        checkOutput("t2_ack",        p1Ack, 1'b1);
        @(negedge clk); p1Req = 1'b0; p1We = 1'b0;
        @(posedge clk); #1;
        checkOutput("t2_ack_done", p1Ack, 1'b0);

        // Simultaneous requests.
`ifdef MEM_ARB_ROUND_ROBIN_EN
        expFirst = 1'b0;
        expOrder = 4'b1010;
`else
        expFirst = 1'b1;
        expOrder = 4'b1111;
`endif
        @(negedge clk);
        p0Req = 1'b1; p0Addr = 32'h200;
        p1Req = 1'b1; p1Addr = 32'h300;
        @(posedge clk); #1;
        checkOutput("t3_first_grant", grantId, expFirst);
        @(posedge clk); #1;
        checkOutput("t3_first_ack", expFirst ? p1Ack : p0Ack, 1'b1);
        @(negedge clk);
        if (expFirst) p1Req = 1'b0; else p0Req = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        checkOutput("t3_second_grant", grantId, !expFirst);
        @(posedge clk); #1;
        checkOutput("t3_second_ack", expFirst ? p0Ack : p1Ack, 1'b1);
        @(negedge clk); p0Req = 1'b0; p1Req = 1'b0;
        @(posedge clk);

        // Both ports requesting continuously for four accesses.
        @(negedge clk);
        p0Req = 1'b1; p0Addr = 32'h400;
        p1Req = 1'b1; p1Addr = 32'h500;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("t4_grant%0d", i), grantId, expOrder[i]);
            @(posedge clk);
            if (i < 3) @(posedge clk);
        end
        @(negedge clk); p1Req = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        checkOutput("t4_p0_grant", grantId, 1'b0);
        @(posedge clk);
        @(negedge clk); p0Req = 1'b0;
        @(posedge clk);

        // Reset during a store access.
        @(negedge clk);
        p1Req = 1'b1; p1We = 1'b1; p1Addr = 32'h600; p1Wdata = 32'h55AA55AA;
        @(posedge clk); #2;
        checkOutput("t5_we_before", ramWe, 1'b1);
        rst = 1'b0;
        #1;
        checkOutput("t5_we_async",   ramWe, 1'b0);
        checkOutput("t5_busy_async", busy,  1'b0);
        p1Req = 1'b0; p1We = 1'b0;
        @(posedge clk); #1;
        checkOutput("t5_no_ack", p1Ack, 1'b0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        p1Req = 1'b1; p1Addr = 32'h700; ramRdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        checkOutput("t5_busy_again", busy, 1'b1);
        @(posedge clk); #1;
        checkOutput("t5_ack",   p1Ack,   1'b1);
        checkOutput("t5_rdata", p1Rdata, 32'hCAFEF00D);
        @(negedge clk); p1Req = 1'b0;

        // Latency 3 on dutB: busy for four cycles, ack after the third edge.
        @(negedge clk);
        bP0Req = 1'b1; bP0Addr = 32'h80; bRamRdata = '0;
        busyCycles = 0; ackCycle = -1; ackCount = 0; gotRd = '0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (bBusy) busyCycles++;
            if (bP0Ack) begin
                ackCycle = k;
                ackCount++;
                gotRd = bP0Rdata;
            end
            @(negedge clk);
            bRamRdata = 32'hA0 + 32'(k + 1);
            if (bP0Ack) bP0Req = 1'b0;
        end
        checkOutput("lat3_busy_cycles", 64'(busyCycles), 64'd4);
        checkOutput("lat3_ack_cycle",   64'(ackCycle),   64'd3);
        checkOutput("lat3_ack_count",   64'(ackCount),   64'd1);
        checkOutput("lat3_rdata",       gotRd,           32'hA3);
        checkOutput("lat3_grant_id",    bGrantId,        1'b0);

        // Random traffic against the model.
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            applyStimulus();
        end
        draining = 1'b1;
        for (int c = 0; c < 60 && (p0Req || p1Req); c++) begin
            @(negedge clk);
            applyStimulus();
        end
        checkOutput("drain_reqs", {p0Req, p1Req}, 2'b00);
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
